// File: rtl/cvxif_mac_pkg.sv
// Shared types and decode for the CV-X-IF packed int8 MAC coprocessor.
// The custom-0 ops live under opcode 7'b0001011 with funct7 = 0.
package cvxif_mac_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] FUNCT7_MAC  = 7'b0000000;
  localparam logic [2:0] F3_DOT4     = 3'b000;
  localparam logic [2:0] F3_DOT4A    = 3'b001;
  localparam logic [2:0] F3_ACCRD    = 3'b010;

  typedef enum logic [1:0] {
    DOT4  = 2'd0,
    DOT4A = 2'd1,
    ACCRD = 2'd2
  } mac_op_e;

  // One speculative instruction: destination, operation and its precomputed dot product.
  typedef struct packed {
    logic [4:0]  rd;
    mac_op_e     op;
    logic [31:0] dot;
  } pend_entry_t;

  typedef struct packed {
    logic    valid;
    mac_op_e op;
  } mac_dec_t;

  // Recognise a coprocessor instruction; anything unknown comes back with valid = 0.
  function automatic mac_dec_t decode_instr(input logic [31:0] instr);
    mac_dec_t dec;
    dec.valid = 1'b0;
    dec.op    = DOT4;
    if (instr[6:0] == OPC_CUSTOM0 && instr[31:25] == FUNCT7_MAC) begin
      case (instr[14:12])
        F3_DOT4:  begin dec.valid = 1'b1; dec.op = DOT4;  end
        F3_DOT4A: begin dec.valid = 1'b1; dec.op = DOT4A; end
        F3_ACCRD: begin dec.valid = 1'b1; dec.op = ACCRD; end
        default:  begin dec.valid = 1'b0; dec.op = DOT4;  end
      endcase
    end
    return dec;
  endfunction

endpackage

// File: rtl/cvxif_mac_pend_fifo.sv
// Pending-instruction circular buffer. Three pointers split it into regions:
// [rptr, cptr) committed and waiting for writeback, [cptr, wptr) still speculative.
// A kill rewinds wptr to cptr, dropping the oldest speculative entry and everything younger.
module cvxif_mac_pend_fifo
  import cvxif_mac_pkg::*;
#(
  parameter int unsigned ID_W  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [ID_W-1:0]   push_id_i,
  input  pend_entry_t       push_entry_i,
  input  logic              commit_i,
  input  logic              kill_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              uncmt_valid_o,
  output logic [ID_W-1:0]   uncmt_id_o,
  output logic              head_cmt_o,
  output logic [ID_W-1:0]   head_id_o,
  output pend_entry_t       head_entry_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] fill;

  pend_entry_t     entry_q [DEPTH];
  logic [ID_W-1:0] id_q    [DEPTH];

  assign fill          = wptr_q - rptr_q;
  assign full_o        = (fill == PW'(DEPTH));
  assign empty_o       = (wptr_q == rptr_q);
  assign uncmt_valid_o = (wptr_q != cptr_q);
  assign uncmt_id_o    = id_q[cptr_q[AW-1:0]];
  assign head_cmt_o    = (rptr_q != cptr_q);
  assign head_id_o     = id_q[rptr_q[AW-1:0]];
  assign head_entry_o  = entry_q[rptr_q[AW-1:0]];

  // Pointer next state; a kill wins over push/commit since the issuer never pushes during one.
  always_comb begin
    wptr_d = wptr_q;
    cptr_d = cptr_q;
    rptr_d = rptr_q;
    if (kill_i) begin
      wptr_d = cptr_q;
    end else begin
      if (push_i)   wptr_d = wptr_q + PW'(1);
      if (commit_i) cptr_d = cptr_q + PW'(1);
    end
    if (pop_i) rptr_d = rptr_q + PW'(1);
  end

  // Pointer registers; reset empties the buffer and drops every pending entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      cptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      cptr_q <= cptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage needs no reset: validity is carried entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      entry_q[wptr_q[AW-1:0]] <= push_entry_i;
      id_q[wptr_q[AW-1:0]]    <= push_id_i;
    end
  end

endmodule

// File: rtl/cvxif_mac_coproc.sv
// CV-X-IF coprocessor executing packed int8 dot-product ops (DOT4, DOT4A, ACCRD).
// Instructions are held speculatively until commit/kill and written back in issue order.
// The accumulator only changes when a committed entry is written back.
// Build option: define CVXIF_MAC_SAT_EN to make DOT4A saturate instead of wrap.
module cvxif_mac_coproc
  import cvxif_mac_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = 2,
  parameter int unsigned PEND_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]           issue_rs1_i,
  input  logic [31:0]           issue_rs2_i,
  output logic                  issue_accept_o,
  output logic                  issue_we_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [4:0]            result_rd_o,
  output logic [31:0]           result_data_o
);

  mac_dec_t              dec;
  logic signed [15:0]    prod [4];
  logic signed [17:0]    dot_sum;
  logic [31:0]           dot32;
  pend_entry_t           push_entry;
  pend_entry_t           head_entry;
  logic                  full, empty, uncmt_valid, head_cmt;
  logic [X_ID_WIDTH-1:0] uncmt_id, head_id;
  logic                  id_match, commit_now, kill_now, push, pop;
  logic [31:0]           acc_q, acc_d, acc_sum, res_data;

  assign dec            = decode_instr(issue_instr_i);
  assign issue_accept_o = dec.valid;
  assign issue_we_o     = dec.valid;

  // One signed 8x8 multiplier per byte lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign prod[gi] = $signed(issue_rs1_i[8*gi +: 8]) * $signed(issue_rs2_i[8*gi +: 8]);
  end

  assign dot_sum = 18'(prod[0]) + 18'(prod[1]) + 18'(prod[2]) + 18'(prod[3]);
  assign dot32   = {{14{dot_sum[17]}}, dot_sum};

  // Commits target the oldest speculative entry; a commit with a foreign id is ignored.
  assign id_match   = uncmt_valid && (commit_id_i == uncmt_id);
  assign commit_now = commit_valid_i && !commit_kill_i && id_match;
  assign kill_now   = commit_valid_i &&  commit_kill_i && id_match;

  // No issue during a kill: the freed slot is offered from the following cycle.
  assign issue_ready_o = !full && !kill_now;
  assign push          = issue_valid_i && issue_ready_o && dec.valid;
  assign pop           = head_cmt && result_ready_i;

  assign push_entry.rd  = issue_instr_i[11:7];
  assign push_entry.op  = dec.op;
  assign push_entry.dot = dot32;

  cvxif_mac_pend_fifo #(
    .ID_W  (X_ID_WIDTH),
    .DEPTH (PEND_DEPTH)
  ) u_pend (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push),
    .push_id_i     (issue_id_i),
    .push_entry_i  (push_entry),
    .commit_i      (commit_now),
    .kill_i        (kill_now),
    .pop_i         (pop),
    .full_o        (full),
    .empty_o       (empty),
    .uncmt_valid_o (uncmt_valid),
    .uncmt_id_o    (uncmt_id),
    .head_cmt_o    (head_cmt),
    .head_id_o     (head_id),
    .head_entry_o  (head_entry)
  );

  // Accumulator update candidate: wrap by default, clamp to int32 range when saturation is built in.
  always_comb begin
    acc_sum = acc_q + head_entry.dot;
`ifdef CVXIF_MAC_SAT_EN
    if ((acc_q[31] == head_entry.dot[31]) && (acc_sum[31] != acc_q[31])) begin
      acc_sum = acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
  end

  // Writeback value for the head entry and the accumulator change applied when it pops.
  always_comb begin
    acc_d    = acc_q;
    res_data = '0;
    case (head_entry.op)
      DOT4: begin
        res_data = head_entry.dot;
      end
      DOT4A: begin
        res_data = acc_sum;
        if (pop) acc_d = acc_sum;
      end
      ACCRD: begin
        res_data = acc_q;
        if (pop) acc_d = '0;
      end
      default: begin
        res_data = '0;
      end
    endcase
  end

  // Accumulator register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  // Result port: driven from held buffer state, so it is stable while stalled and zero when idle.
  assign result_valid_o = head_cmt;
  assign result_id_o    = head_cmt ? head_id       : '0;
  assign result_rd_o    = head_cmt ? head_entry.rd : '0;
  assign result_data_o  = head_cmt ? res_data      : '0;

`ifndef SYNTHESIS
  // A commit must name the oldest speculative instruction.
  a_commit_id : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (commit_valid_i && uncmt_valid) |-> (commit_id_i == uncmt_id))
    else $error("commit id does not match oldest uncommitted entry");

  // A committed head implies the buffer holds something.
  a_head_nonempty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    head_cmt |-> !empty)
    else $error("committed head in empty buffer");
`endif

endmodule
